// File: rtl/fft_pkg.sv
// Shared types and constants for the small radix-2 FFT blocks.
// Latency: n/a (types, twiddle ROM, bit-reverse table, FSM states).
// Backpressure: n/a.
package fft_pkg;

    typedef logic signed [15:0] sample_t;

    typedef struct packed {
        sample_t re;
        sample_t im;
    } cplx_t;

    // W8^k for k = 0..3 in Q1.15; W0 and W2 never reach the multiplier.
    localparam sample_t TW_RE [4] = '{16'sd32767, 16'sd23170, 16'sd0, -16'sd23170};
    localparam sample_t TW_IM [4] = '{16'sd0, -16'sd23170, -16'sd32767, -16'sd23170};

    localparam logic [2:0] BIT_REV [8] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_S1,
        ST_S2,
        ST_S3,
        ST_DONE
    } state_t;

endpackage

// File: rtl/fft_bfly_r2.sv
// Radix-2 DIT butterfly with halving: a' = (a+bW)>>>1, b' = (a-bW)>>>1.
// Latency: combinational.
// Backpressure: none.
module fft_bfly_r2
    import fft_pkg::*;
(
    input  cplx_t      a,
    input  cplx_t      b,
    input  logic [1:0] tw,
    output cplx_t      a_out,
    output cplx_t      b_out
);

    logic signed [31:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [32:0] m_re, m_im;
    logic signed [17:0] t_re, t_im;
    logic signed [17:0] s_re, s_im, d_re, d_im;

    assign p_rr = b.re * TW_RE[tw];
    assign p_ii = b.im * TW_IM[tw];
    assign p_ri = b.re * TW_IM[tw];
    assign p_ir = b.im * TW_RE[tw];
    assign m_re = 33'(p_rr) - 33'(p_ii);
    assign m_im = 33'(p_ri) + 33'(p_ir);

    always_comb begin
        t_re = 18'(b.re);
        t_im = 18'(b.im);
        case (tw)
            2'd0: begin
                t_re = 18'(b.re);
                t_im = 18'(b.im);
            end
            // Multiply by -j: (re, im) -> (im, -re), exact.
            2'd2: begin
                t_re = 18'(b.im);
                t_im = -18'(b.re);
            end
            default: begin
                t_re = 18'(m_re >>> 15);
                t_im = 18'(m_im >>> 15);
            end
        endcase
    end

    always_comb begin
        s_re     = 18'(a.re) + t_re;
        s_im     = 18'(a.im) + t_im;
        d_re     = 18'(a.re) - t_re;
        d_im     = 18'(a.im) - t_im;
        a_out.re = 16'(s_re >>> 1);
        a_out.im = 16'(s_im >>> 1);
        b_out.re = 16'(d_re >>> 1);
        b_out.im = 16'(d_im >>> 1);
    end

endmodule

// File: rtl/fft8_sol0_gen2.sv
// Single-shot 8-point complex FFT (scaled by 1/8), parallel load, parallel registered result.
// Latency: start sampled at edge k, result and done valid after edge k+3.
// Backpressure: none; start is ignored while a transform is running.
module fft8_sol0_gen2
    import fft_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] data_in_real  [8],
    input  logic [15:0] data_in_imag  [8],
    output logic [15:0] data_out_real [8],
    output logic [15:0] data_out_imag [8],
    output logic        done
);

    state_t     state, state_nxt;
    logic       accept;
    cplx_t      work  [8];
    cplx_t      nxt   [8];
    cplx_t      bf_a  [4];
    cplx_t      bf_b  [4];
    cplx_t      bf_ao [4];
    cplx_t      bf_bo [4];
    logic [1:0] bf_tw [4];
    logic [2:0] idx_a [4];
    logic [2:0] idx_b [4];

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = ST_S1;
                end
            end
            ST_S1:   state_nxt = ST_S2;
            ST_S2:   state_nxt = ST_S3;
            ST_S3:   state_nxt = ST_DONE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Butterfly j of a stage with span sp pairs (a, a+sp), twiddle (j mod sp)*(4/sp).
    always_comb begin
        int sp;
        int ia;
        sp = 1;
        case (state)
            ST_S2:   sp = 2;
            ST_S3:   sp = 4;
            default: sp = 1;
        endcase
        for (int j = 0; j < 4; j++) begin
            ia       = (j / sp) * 2 * sp + (j % sp);
            idx_a[j] = 3'(ia);
            idx_b[j] = 3'(ia + sp);
            bf_tw[j] = 2'((j % sp) * (4 / sp));
            bf_a[j]  = work[idx_a[j]];
            bf_b[j]  = work[idx_b[j]];
        end
    end

    for (genvar j = 0; j < 4; j++) begin : g_bfly
        fft_bfly_r2 u_bfly (
            .a     (bf_a[j]),
            .b     (bf_b[j]),
            .tw    (bf_tw[j]),
            .a_out (bf_ao[j]),
            .b_out (bf_bo[j])
        );
    end

    always_comb begin
        nxt = work;
        for (int j = 0; j < 4; j++) begin
            nxt[idx_a[j]] = bf_ao[j];
            nxt[idx_b[j]] = bf_bo[j];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < 8; n++) begin
                work[n]          <= '0;
                data_out_real[n] <= '0;
                data_out_imag[n] <= '0;
            end
            done <= 1'b0;
        end else if (accept) begin
            for (int n = 0; n < 8; n++) begin
                work[n].re <= data_in_real[BIT_REV[n]];
                work[n].im <= data_in_imag[BIT_REV[n]];
            end
            done <= 1'b0;
        end else if (state == ST_S1 || state == ST_S2) begin
            work <= nxt;
        end else if (state == ST_S3) begin
            for (int n = 0; n < 8; n++) begin
                data_out_real[n] <= nxt[n].re;
                data_out_imag[n] <= nxt[n].im;
            end
            done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fft8_sol0_gen2.sv
// Bench for fft8_sol0_gen2: literal vectors, a tone against a floating-point DFT,
// randomized vectors against a bit-exact integer FFT model, and handshake/reset cases.
module tb_fft8_sol0_gen2;

    localparam real PI = 3.14159265358979323846;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] data_in_real  [8];
    logic [15:0] data_in_imag  [8];
    logic [15:0] data_out_real [8];
    logic [15:0] data_out_imag [8];
    logic        done;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;
    bit exp_done;
    int exp_re [8];
    int exp_im [8];
    int tol;

    fft8_sol0_gen2 dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .data_in_real  (data_in_real),
        .data_in_imag  (data_in_imag),
        .data_out_real (data_out_real),
        .data_out_imag (data_out_imag),
        .done          (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int k, input int act, input int exp, input int t);
        int d;
        checks++;
        d = act - exp;
        if (d < 0) d = -d;
        if (d > t) begin
            errors++;
            $display("FAIL %s[%0d] @%0t: got %0d expected %0d (tol %0d)", nm, k, $time, act, exp, t);
        end
    endtask

    // Integer DIT FFT following the arithmetic rules: floor halving each stage,
    // multiply twiddles truncated by >>>15, results wrapped to 16 bits.
    function automatic void fft_model(input int xr[8], input int xi[8], output int yr[8], output int yi[8]);
        longint wr [8];
        longint wi [8];
        longint ar, ai, br, bi, tr, ti, cr, ci;
        int a, b, k, r;
        for (int n = 0; n < 8; n++) begin
            r = ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
            wr[n] = xr[r];
            wi[n] = xi[r];
        end
        for (int sp = 1; sp < 8; sp = sp * 2) begin
            for (int g = 0; g < 8; g += 2 * sp) begin
                for (int p = 0; p < sp; p++) begin
                    a = g + p;
                    b = a + sp;
                    k = p * (4 / sp);
                    ar = wr[a]; ai = wi[a]; br = wr[b]; bi = wi[b];
                    if (k == 0) begin
                        tr = br; ti = bi;
                    end else if (k == 2) begin
                        tr = bi; ti = -br;
                    end else begin
                        cr = (k == 1) ? 23170 : -23170;
                        ci = -23170;
                        tr = (br * cr - bi * ci) >>> 15;
                        ti = (br * ci + bi * cr) >>> 15;
                    end
                    wr[a] = (ar + tr) >>> 1;
                    wi[a] = (ai + ti) >>> 1;
                    wr[b] = (ar - tr) >>> 1;
                    wi[b] = (ai - ti) >>> 1;
                end
            end
        end
        for (int n = 0; n < 8; n++) begin
            yr[n] = int'($signed(16'(wr[n])));
            yi[n] = int'($signed(16'(wi[n])));
        end
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("done", 0, int'(done), int'(exp_done), 0);
            for (int k = 0; k < 8; k++) begin
                chk("re", k, int'($signed(data_out_real[k])), exp_re[k], tol);
                chk("im", k, int'($signed(data_out_imag[k])), exp_im[k], tol);
            end
        end
    end

    task automatic drive_random();
        for (int n = 0; n < 8; n++) begin
            data_in_real[n] = 16'($urandom);
            data_in_imag[n] = 16'($urandom);
        end
    endtask

    task automatic run_fft(input int xr[8], input int xi[8], input int er[8], input int ei[8],
                           input int t, input bit glitch);
        @(negedge clk);
        for (int n = 0; n < 8; n++) begin
            data_in_real[n] = 16'(xr[n]);
            data_in_imag[n] = 16'(xi[n]);
        end
        start = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        exp_done = 1'b0;
        drive_random();
        @(posedge clk); #1;
        // Now in the second stage: a start here with fresh data must be ignored.
        if (glitch) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        exp_done = 1'b1;
        exp_re   = er;
        exp_im   = ei;
        tol      = t;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int xr [8];
        int xi [8];
        int er [8];
        int ei [8];
        int mr [8];
        int mi [8];
        real sr, si, ang;

        rst   = 1'b1;
        start = 1'b1;
        drive_random();
        exp_done = 1'b0;
        tol      = 0;
        for (int n = 0; n < 8; n++) begin
            exp_re[n] = 0;
            exp_im[n] = 0;
        end
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        rst   = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Impulse
        for (int n = 0; n < 8; n++) begin
            xr[n] = 0; xi[n] = 0; er[n] = 16'h0800; ei[n] = 0;
        end
        xr[0] = 16'h4000;
        fft_model(xr, xi, mr, mi);
        for (int k = 0; k < 8; k++) chk("model_impulse", k, mr[k], 2048, 0);
        run_fft(xr, xi, er, ei, 0, 1'b0);

        // DC on both rails
        for (int n = 0; n < 8; n++) begin
            xr[n] = 16'h4000; xi[n] = 16'h4000; er[n] = 0; ei[n] = 0;
        end
        er[0] = 16'h4000;
        ei[0] = 16'h4000;
        fft_model(xr, xi, mr, mi);
        chk("model_dc_re", 0, mr[0], 16384, 0);
        chk("model_dc_im", 0, mi[0], 16384, 0);
        chk("model_dc_re", 5, mr[5], 0, 0);
        run_fft(xr, xi, er, ei, 0, 1'b1);

        // Alternating sign
        for (int n = 0; n < 8; n++) begin
            xr[n] = (n % 2 == 0) ? 16384 : -16384; xi[n] = 0; er[n] = 0; ei[n] = 0;
        end
        er[4] = 16384;
        fft_model(xr, xi, mr, mi);
        chk("model_alt", 4, mr[4], 16384, 0);
        chk("model_alt", 0, mr[0], 0, 0);
        run_fft(xr, xi, er, ei, 0, 1'b0);

        // Single tone at bin 1 against a floating-point DFT
        for (int n = 0; n < 8; n++) begin
            xr[n] = int'(16384.0 * $cos(2.0 * PI * n / 8.0));
            xi[n] = int'(16384.0 * $sin(2.0 * PI * n / 8.0));
        end
        for (int k = 0; k < 8; k++) begin
            sr = 0.0; si = 0.0;
            for (int n = 0; n < 8; n++) begin
                ang = 2.0 * PI * n * k / 8.0;
                sr += xr[n] * $cos(ang) + xi[n] * $sin(ang);
                si += xi[n] * $cos(ang) - xr[n] * $sin(ang);
            end
            er[k] = int'(sr / 8.0);
            ei[k] = int'(si / 8.0);
        end
        chk("dft_tone", 1, er[1], 16384, 1);
        run_fft(xr, xi, er, ei, 2, 1'b0);

        // Randomized vectors, back-to-back, some with an ignored mid-transform start
        for (int it = 0; it < 16; it++) begin
            for (int n = 0; n < 8; n++) begin
                xr[n] = int'($urandom_range(0, 32766)) - 16383;
                xi[n] = int'($urandom_range(0, 32766)) - 16383;
            end
            fft_model(xr, xi, er, ei);
            run_fft(xr, xi, er, ei, 0, ($urandom_range(0, 1) == 1));
        end

        // Reset during the second stage: partial result discarded, done never rises
        @(negedge clk);
        drive_random();
        start = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        exp_done = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int n = 0; n < 8; n++) begin
            exp_re[n] = 0;
            exp_im[n] = 0;
        end
        tol = 0;
        repeat (6) @(posedge clk);
        #1;

        // Recovery after the aborted transform
        for (int n = 0; n < 8; n++) begin
            xr[n] = int'($urandom_range(0, 32766)) - 16383;
            xi[n] = int'($urandom_range(0, 32766)) - 16383;
        end
        fft_model(xr, xi, er, ei);
        run_fft(xr, xi, er, ei, 0, 1'b0);

        @(negedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
